// File: rtl/tft_spi_monitor.sv
// rtl/tft_spi_monitor.sv - TFT SPI receive monitor: byte rebuild, CASET/PASET/RAMWR decode, pixel stream
module tft_spi_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int COORD_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_clk,
    input  logic               spi_mosi,
    input  logic               spi_dc,
    input  logic               spi_cs,
    output logic [7:0]         byte_out,
    output logic               byte_dc,
    output logic               byte_valid,
    output logic               cmd_valid,
    output logic [COORD_W-1:0] x_start,
    output logic [COORD_W-1:0] x_end,
    output logic [COORD_W-1:0] y_start,
    output logic [COORD_W-1:0] y_end,
    output logic [15:0]        pixel,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    output logic               stray_data
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CASET = 3'd1;
    localparam logic [2:0] ST_PASET = 3'd2;
    localparam logic [2:0] ST_RAMWR = 3'd3;
    localparam logic [2:0] ST_SKIP  = 3'd4;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
    logic                   sclk_s, mosi_s, dc_s, cs_s, sclk_prev, sclk_rise;
    logic [2:0]             bit_cnt;
    logic [6:0]             sr;
    logic [2:0]             state;
    logic [1:0]             idx;
    logic                   phase;
    logic [7:0]             start_hi, start_lo, end_hi, hi_byte;

    // Zero-extend or truncate a 16-bit wire value into the coordinate width.
    function automatic logic [COORD_W-1:0] to_coord(input logic [15:0] v);
        logic [COORD_W+15:0] ext;
        ext = {{COORD_W{1'b0}}, v};
        return ext[COORD_W-1:0];
    endfunction

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_s;

    // Bring the asynchronous bus into the clk domain; idle is clock low, deselected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            cs_sync   <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
        end
    end

    // Shift bits on rising serial clock; an 8th edge coinciding with the cs rise still completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_prev  <= 1'b0;
            bit_cnt    <= 3'd0;
            sr         <= 7'd0;
            byte_out   <= 8'd0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
            cmd_valid  <= 1'b0;
        end else begin
            sclk_prev  <= sclk_s;
            byte_valid <= 1'b0;
            cmd_valid  <= 1'b0;
            if (sclk_rise && (!cs_s || bit_cnt == 3'd7)) begin
                sr <= {sr[5:0], mosi_s};
                if (bit_cnt == 3'd7) begin
                    byte_out   <= {sr, mosi_s};
                    byte_dc    <= dc_s;
                    byte_valid <= 1'b1;
                    cmd_valid  <= ~dc_s;
                    bit_cnt    <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (cs_s) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    // Command decoder, window parameter capture, pixel assembly and address walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            phase       <= 1'b0;
            start_hi    <= 8'd0;
            start_lo    <= 8'd0;
            end_hi      <= 8'd0;
            hi_byte     <= 8'd0;
            x_start     <= '0;
            x_end       <= '0;
            y_start     <= '0;
            y_end       <= '0;
            pixel       <= 16'd0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            stray_data  <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (byte_valid) begin
                if (!byte_dc) begin
                    idx   <= 2'd0;
                    phase <= 1'b0;
                    case (byte_out)
                        8'h2A: state <= ST_CASET;
                        8'h2B: state <= ST_PASET;
                        8'h2C: begin
                            state   <= ST_RAMWR;
                            pixel_x <= x_start;
                            pixel_y <= y_start;
                        end
                        default: state <= ST_SKIP;
                    endcase
                end else begin
                    case (state)
                        ST_IDLE: stray_data <= 1'b1;
                        ST_CASET, ST_PASET: begin
                            idx <= idx + 2'd1;
                            case (idx)
                                2'd0: start_hi <= byte_out;
                                2'd1: start_lo <= byte_out;
                                2'd2: end_hi   <= byte_out;
                                default: begin
                                    if (state == ST_CASET) begin
                                        x_start <= to_coord({start_hi, start_lo});
                                        x_end   <= to_coord({end_hi, byte_out});
                                    end else begin
                                        y_start <= to_coord({start_hi, start_lo});
                                        y_end   <= to_coord({end_hi, byte_out});
                                    end
                                    state <= ST_SKIP;
                                end
                            endcase
                        end
                        ST_RAMWR: begin
                            if (!phase) begin
                                hi_byte <= byte_out;
                                phase   <= 1'b1;
                            end else begin
                                pixel       <= {hi_byte, byte_out};
                                pixel_valid <= 1'b1;
                                phase       <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (pixel_valid) begin
                // Anything not strictly inside the window falls through to row step or wrap.
                if (pixel_x < x_end) begin
                    pixel_x <= pixel_x + COORD_W'(1);
                end else if (pixel_y < y_end) begin
                    pixel_x <= x_start;
                    pixel_y <= pixel_y + COORD_W'(1);
                end else begin
                    pixel_x <= x_start;
                    pixel_y <= y_start;
                end
            end
        end
    end

endmodule
